instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Sequential front end that feeds the control main decoder and datapath.
//  - Holds the PC and issues word reads to instruction memory over a request/response handshake.
//  - Buffers returned words in a small FIFO and presents them with PC and pre-split Op/Funct fields on a valid/ready port.
//  - Accepts branch redirects from execute and discards wrong-path fetches.
// PARAMETERS
//  ADDR_W      32  width of PC / memory address
//  DEPTH       2   instruction FIFO entries (power of two, >=2)
//  RESET_PC    0   PC value loaded on reset
// PORTS
//  clk             in   1       clock, all state updates on rising edge
//  rst             in   1       synchronous reset, active-high
//  imem_req_valid  out  1       fetch request valid
//  imem_req_ready  in   1       memory accepts request this cycle
//  imem_req_addr   out  ADDR_W  word-aligned fetch address
//  imem_rsp_valid  in   1       read data valid (in order, latency >=1 cycle)
//  imem_rsp_data   in   32      instruction word
//  redirect_valid  in   1       branch taken; refetch from redirect_pc
//  redirect_pc     in   ADDR_W  branch target
//  instr_valid     out  1       FIFO head valid toward decoder
//  instr_ready     in   1       decoder/datapath consumes head
//  instr_data      out  32      head instruction word
//  instr_pc        out  ADDR_W  address of head instruction
//  instr_op        out  2       instr_data[27:26]
//  instr_funct     out  6       instr_data[25:20]
//  misalign_err    out  1       sticky misaligned-redirect flag
// BEHAVIOUR
//  - Reset: pc=RESET_PC; FIFO empty; outstanding=0; discard=0; all outputs 0. First request at earliest in the first cycle with rst low.
//  - Max one outstanding request. imem_req_valid=1 iff !rst && outstanding==0 && (fifo_count)<DEPTH && !redirect_valid.
//  - imem_req_addr=pc. On req handshake: outstanding<=1, pc<=pc+4 (wraps modulo 2^ADDR_W).
//  - rsp_valid with outstanding==1 and discard==0: push {data, pc_of_req} to FIFO.
//  - rsp_valid always clears outstanding and discard. rsp_valid with outstanding==0 is ignored.
//  - FIFO full at DEPTH: never overflows, because requests are not issued when count==DEPTH.
//  - Push and pop in the same cycle keep the count unchanged.
//  - Output: instr_* are registered FIFO head; stable while instr_valid && !instr_ready. Pop on instr_valid && instr_ready.
//  - Redirect (priority over everything except rst):
//    - FIFO flushed next cycle (instr_valid=0); pc<=redirect_pc.
//    - If a request is outstanding or a response arrives in the same cycle, that response is dropped.
//      discard<=1 when still outstanding.
//    - No new request is issued in the redirect cycle. A concurrent pop is void.
//  - Redirect latency: first request to the target issues the cycle after redirect if outstanding==0.
//    Otherwise the request issues the cycle after the discarded response returns.
//  - FSM (derived): FETCH (may request) -> WAIT (outstanding) -> FETCH on rsp;
//    WAIT + redirect -> DRAIN (discard) -> FETCH on rsp.
//  - rst mid-operation: state cleared in that cycle; a later stray rsp is ignored (outstanding==0).
// CONFIGURATION
//  IFU_ALIGN_CHECK_EN
//   - Defined: redirect_valid with redirect_pc[1:0]!=0 sets misalign_err=1 (sticky until rst).
//     pc is loaded with {redirect_pc[ADDR_W-1:2],2'b00}.
//   - Undefined: misalign_err tied 0; redirect_pc[1:0] silently forced to 00.
// TESTING
//  1 Reset, RESET_PC=0, mem latency 1, instr_ready=1
//    -> req addrs 0,4,8,...; instr_pc tracks; first instr_valid 2 cycles after first req.
//  2 instr_ready=0 for 10 cycles
//    -> exactly DEPTH words buffered, imem_req_valid=0, head stable; release -> in-order drain, no loss.
//  3 Redirect to 0x100 while req at 0x8 outstanding (latency 3)
//    -> 0x8 data never appears; next instr_pc=0x100.
//  4 Redirect coincident with rsp_valid and instr_ready
//    -> rsp dropped, FIFO empty next cycle, req to target following cycle.
//  5 pc=0xFFFFFFFC fetch
//    -> next req addr 0x0.
//  6 With IFU_ALIGN_CHECK_EN, redirect to 0x102
//    -> misalign_err=1, req addr 0x100; stays 1 until rst.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : PC register, single-outstanding imem fetch, DEPTH-entry
//             instruction FIFO and branch redirect with wrong-path discard.
//  Options  : IFU_ALIGN_CHECK_EN enables the sticky misalign_err flag.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [1:0]        instr_op,
    output logic [5:0]        instr_funct,
    output logic              misalign_err
);

    localparam int                PTR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W        = PTR_W + 1;
    localparam logic [CNT_W-1:0]  c_depth      = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_pc_inc     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_align_mask = ADDR_W'(3);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        mem_data_q [DEPTH];
    logic [31:0]        mem_data_d [DEPTH];
    logic [ADDR_W-1:0]  mem_pc_q   [DEPTH];
    logic [ADDR_W-1:0]  mem_pc_d   [DEPTH];

    logic               w_req_fire;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_redirect_tgt;

    assign w_redirect_tgt = redirect_pc & ~c_align_mask;

    assign imem_req_valid = !rst && (state_q == ST_FETCH) && (count_q < c_depth)
                            && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Only a response to a live (non-discarded) request enters the FIFO.
    assign w_push = imem_rsp_valid && (state_q == ST_WAIT) && !redirect_valid;

    assign instr_valid = !rst && (count_q != '0);
    assign w_pop       = instr_valid && instr_ready && !redirect_valid;

    assign instr_data  = mem_data_q[rd_ptr_q];
    assign instr_pc    = mem_pc_q[rd_ptr_q];
    assign instr_op    = instr_data[27:26];
    assign instr_funct = instr_data[25:20];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH: begin
                if (w_req_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A redirect coinciding with the response drops it and needs no drain.
                if (imem_rsp_valid) begin
                    state_d = ST_FETCH;
                end else if (redirect_valid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_data_d = mem_data_q;
        mem_pc_d   = mem_pc_q;

        if (redirect_valid) begin
            pc_d = w_redirect_tgt;
        end else if (w_req_fire) begin
            pc_d     = pc_q + c_pc_inc;
            req_pc_d = pc_q;
        end

        if (w_push) begin
            mem_data_d[wr_ptr_q] = imem_rsp_data;
            mem_pc_d[wr_ptr_q]   = req_pc_q;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_pc_q[i]   <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_data_q <= mem_data_d;
            mem_pc_q   <= mem_pc_d;
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign misalign_err = err_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Directed self-checking bench for instr_fetch_unit with an
//             in-order fixed-latency instruction memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [1:0]  instr_op;
    logic [5:0]  instr_funct;
    logic        misalign_err;

    int          n_total = 0;
    int          n_pass  = 0;
    int          lat     = 1;
    int          nreq    = 0;
    int          ninstr  = 0;
    logic [31:0] exp_req = '0;
    logic [31:0] exp_pc  = '0;
    logic [31:0] pq_addr [$];
    int          pq_cnt  [$];

`ifdef IFU_ALIGN_CHECK_EN
    localparam logic [31:0] c_exp_err = 32'd1;
`else
    localparam logic [31:0] c_exp_err = 32'd0;
`endif

    instr_fetch_unit #(
        .ADDR_W   (32),
        .DEPTH    (2),
        .RESET_PC (32'h0)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_op       (instr_op),
        .instr_funct    (instr_funct),
        .misalign_err   (misalign_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'h0DF0_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; the memory model answers each accepted request 'lat' cycles later.
    task automatic tick();
        logic        hs;
        logic [31:0] ha;
        #3;
        hs = imem_req_valid && imem_req_ready;
        ha = imem_req_addr;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (hs) begin
            pq_addr.push_back(ha);
            pq_cnt.push_back(lat);
        end
        foreach (pq_cnt[i]) pq_cnt[i]--;
        if (pq_cnt.size() > 0 && pq_cnt[0] <= 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memw(pq_addr[0]);
            void'(pq_addr.pop_front());
            void'(pq_cnt.pop_front());
        end
    endtask

    task automatic observe();
        logic [31:0] w;
        #1;
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req);
            exp_req = exp_req + 32'd4;
            nreq++;
        end
        if (instr_valid && instr_ready) begin
            w = memw(exp_pc);
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr_data", instr_data, w);
            chk("instr_op", 32'(instr_op), 32'(w[27:26]));
            chk("instr_funct", 32'(instr_funct), 32'(w[25:20]));
            exp_pc = exp_pc + 32'd4;
            ninstr++;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        pq_addr.delete();
        pq_cnt.delete();
        tick();
        tick();
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_instr_data", instr_data, 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        rst     = 1'b0;
        exp_req = '0;
        exp_pc  = '0;
        nreq    = 0;
        ninstr  = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time got 100000 expected below 100000");
        $fatal(1, "bench timeout");
    end

    initial begin
        int          n0;
        logic        got;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;

        // Streaming with latency 1: request every other cycle, instr 2 cycles after request.
        lat = 1;
        do_reset();
        #1;
        chk("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_first_req_addr", imem_req_addr, 32'h0);
        for (int i = 0; i < 20; i++) begin
            if (i == 1) chk("t1_not_yet_valid", 32'(instr_valid), 32'd0);
            if (i == 2) chk("t1_first_valid", 32'(instr_valid), 32'd1);
            observe();
            tick();
        end
        chk("t1_nreq", nreq, 32'd10);
        chk("t1_ninstr", ninstr, 32'd9);

        // Back-pressure: FIFO fills to DEPTH, requests stop, head holds.
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            observe();
            chk("t2_head_pc", instr_pc, exp_pc);
            tick();
        end
        #1;
        chk("t2_full_no_req", 32'(imem_req_valid), 32'd0);
        chk("t2_head_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        observe();
        tick();
        observe();
        tick();
        #1;
        chk("t2_drained_two", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            observe();
            tick();
        end
        chk("t2_ninstr", ninstr, 32'd14);

        // Redirect while the 0x8 fetch is outstanding (latency 3).
        lat = 3;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            observe();
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("t3_no_req_in_redirect", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        exp_req = 32'h100;
        exp_pc  = 32'h100;
        #1;
        chk("t3_drain_no_req_a", 32'(imem_req_valid), 32'd0);
        chk("t3_drain_empty", 32'(instr_valid), 32'd0);
        tick();
        #1;
        chk("t3_drain_no_req_b", 32'(imem_req_valid), 32'd0);
        tick();
        #1;
        chk("t3_target_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t3_target_req_addr", imem_req_addr, 32'h100);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!got && instr_valid) begin
                chk("t3_op", 32'(instr_op), 32'd3);
                chk("t3_funct", 32'(instr_funct), 32'h1F);
                got = 1'b1;
            end
            observe();
            tick();
        end
        chk("t3_target_instr_seen", 32'(got), 32'd1);

        // Redirect together with a response and a pop.
        lat         = 1;
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            observe();
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        instr_ready    = 1'b1;
        #1;
        chk("t4_head_valid", 32'(instr_valid), 32'd1);
        chk("t4_no_req_in_redirect", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t4_flushed", 32'(instr_valid), 32'd0);
        chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_req_addr", imem_req_addr, 32'h40);
        exp_req = 32'h40;
        exp_pc  = 32'h40;
        n0      = ninstr;
        for (int i = 0; i < 6; i++) begin
            observe();
            tick();
        end
        chk("t4_ninstr", ninstr - n0, 32'd2);

        // PC wrap from 0xFFFFFFFC.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        chk("t5_no_req_in_redirect", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t5_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t5_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        exp_req = 32'hFFFF_FFFC;
        exp_pc  = 32'hFFFF_FFFC;
        observe();
        tick();
        observe();
        tick();
        #1;
        chk("t5_wrap_valid", 32'(imem_req_valid), 32'd1);
        chk("t5_wrap_addr", imem_req_addr, 32'h0);
        observe();
        tick();

        // Misaligned redirect target: low bits dropped, flag per build.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        #1;
        chk("t6_err_before", 32'(misalign_err), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t6_err_set", 32'(misalign_err), c_exp_err);
        chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_req_aligned", imem_req_addr, 32'h100);
        exp_req = 32'h100;
        exp_pc  = 32'h100;
        for (int i = 0; i < 6; i++) begin
            observe();
            tick();
        end
        chk("t6_err_sticky", 32'(misalign_err), c_exp_err);

        // Reset mid-fetch; the stray response must be ignored afterwards.
        lat = 3;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            observe();
            tick();
        end
        rst = 1'b1;
        #1;
        chk("t7_rst_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        chk("t7_after_rst_empty", 32'(instr_valid), 32'd0);
        tick();
        #1;
        chk("t7_stray_cycle_empty", 32'(instr_valid), 32'd0);
        tick();
        #1;
        chk("t7_stray_ignored", 32'(instr_valid), 32'd0);
        imem_req_ready = 1'b1;
        exp_req = 32'h0;
        exp_pc  = 32'h0;
        n0      = ninstr;
        for (int i = 0; i < 6; i++) begin
            observe();
            tick();
        end
        chk("t7_ninstr", ninstr - n0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
